embedding_mean_pool: RTL



---
 rtl/embedding_mean_pool_pkg.sv | 23 ++
 rtl/embedding_mean_pool_if.sv | 28 ++
 rtl/embedding_mean_pool_recip.sv | 57 +++++
 rtl/embedding_mean_pool.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/embedding_mean_pool_pkg.sv
// Shared types and helpers for the sentence-embedding pooling datapath.
// Values are signed Q16.16 carried in DATA_W-bit lanes.
package rag_csd_encoder_pkg;

  localparam int DATA_W = 32;
  localparam int FRAC_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    ACCUM,
    RECIP,
    EMIT,
    DONE
  } pool_state_t;

  // Signed clamp of a 64-bit intermediate into the 32-bit lane range.
  function automatic logic signed [DATA_W-1:0] sat32(input logic signed [63:0] v);
    if (v > 64'sd2147483647) return 32'sh7fff_ffff;
    if (v < -64'sd2147483648) return 32'sh8000_0000;
    return v[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/embedding_mean_pool_if.sv
// Token-in / pooled-row-out beat streams of the mean-pooling block.
// Both streams: a beat transfers on a clock edge where valid && ready; the
// source holds data (and last) stable while valid is high and ready is low.
interface embedding_mean_pool_if
  import rag_csd_encoder_pkg::*;
#(
  parameter int LANES = 16
) ();

  logic                    in_valid;
  logic                    in_ready;
  logic [LANES*DATA_W-1:0] in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [LANES*DATA_W-1:0] out_data;
  logic                    out_last;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

endinterface

// File: rtl/embedding_mean_pool_recip.sv
// Serial restoring divider producing floor(2^RECIP_FRAC / n), one quotient
// bit per cycle, MSB first; done pulses exactly RECIP_FRAC+1 cycles after start.
module pool_recip_divider
  import rag_csd_encoder_pkg::*;
#(
  parameter int MAX_TOKENS = 128,
  parameter int RECIP_FRAC = 24,
  localparam int N_W   = $clog2(MAX_TOKENS) + 1,
  localparam int Q_W   = RECIP_FRAC + 1,
  localparam int CNT_W = $clog2(Q_W + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N_W-1:0] divisor,
  output logic           done,
  output logic [Q_W-1:0] quotient
);

  logic [N_W-1:0]   rem;
  logic [N_W-1:0]   div_reg;
  logic [Q_W-1:0]   dvd;
  logic [CNT_W-1:0] cnt;
  logic [N_W:0]     trial;
  logic             ge;

  // Remainder stays below the divisor, so the trial value fits in N_W+1 bits.
  assign trial = {rem, dvd[Q_W-1]};
  assign ge    = trial >= {1'b0, div_reg};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem      <= '0;
      div_reg  <= '0;
      dvd      <= '0;
      cnt      <= '0;
      quotient <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem      <= '0;
        div_reg  <= divisor;
        dvd      <= Q_W'(1) << RECIP_FRAC;
        cnt      <= CNT_W'(Q_W);
        quotient <= '0;
      end else if (cnt != '0) begin
        rem      <= ge ? N_W'(trial - {1'b0, div_reg}) : trial[N_W-1:0];
        quotient <= {quotient[Q_W-2:0], ge};
        dvd      <= dvd << 1;
        cnt      <= cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) done <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/embedding_mean_pool.sv
// Accumulates token embeddings element-wise over a sequence, then streams the
// mean-pooled vector out row by row (acc * floor(2^RECIP_FRAC/n) >>> RECIP_FRAC).
module embedding_mean_pool
  import rag_csd_encoder_pkg::*;
#(
  parameter int EMBEDDING_DIM = 384,
  parameter int MAX_TOKENS    = 128,
  parameter int LANES         = 16,
  parameter int RECIP_FRAC    = 24,
  localparam int N_W = $clog2(MAX_TOKENS) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [N_W-1:0]    sequence_length,
  output logic              busy,
  output logic              done,
  output logic              error,
  output pool_state_t       fsm_state,
  embedding_mean_pool_if.slave bus
);

  localparam int ROWS  = EMBEDDING_DIM / LANES;
  localparam int ROW_W = $clog2(ROWS);
  localparam int ACC_W = DATA_W + $clog2(MAX_TOKENS);
  localparam int Q_W   = RECIP_FRAC + 1;

  pool_state_t        state;
  logic [N_W-1:0]     n_lat;
  logic [N_W-1:0]     tok_cnt;
  logic [ROW_W-1:0]   row_cnt;
  logic               run_err;
  logic               accept;
  logic               row_last;
  logic               div_start;
  logic               div_done;
  logic [Q_W-1:0]     recip;

  logic [LANES*ACC_W-1:0]  acc_mem [ROWS];
  logic [LANES*ACC_W-1:0]  acc_rd;
  logic [LANES*ACC_W-1:0]  acc_wdata;
  logic [LANES*DATA_W-1:0] row_out;

  function automatic logic [ACC_W-1:0] acc_update(input logic [ACC_W-1:0] old,
                                                  input logic [DATA_W-1:0] lane,
                                                  input logic first);
    logic [ACC_W-1:0] ext;
    ext = {{(ACC_W-DATA_W){lane[DATA_W-1]}}, lane};
    return first ? ext : old + ext;
  endfunction

  function automatic logic [DATA_W-1:0] scale(input logic [ACC_W-1:0] a,
                                              input logic [Q_W-1:0] r);
    logic signed [63:0] a64;
    logic signed [63:0] r64;
    logic signed [63:0] p;
    a64 = {{(64-ACC_W){a[ACC_W-1]}}, a};
    r64 = {{(64-Q_W){1'b0}}, r};
    p   = a64 * r64;
    return sat32(p >>> RECIP_FRAC);
  endfunction

  assign fsm_state = state;
  assign accept    = (state == ACCUM) && bus.in_valid && bus.in_ready;
  assign row_last  = row_cnt == ROW_W'(ROWS - 1);
  assign div_start = accept && row_last && ((tok_cnt + N_W'(1)) == n_lat);
  assign acc_rd    = acc_mem[row_cnt];

  always_comb begin
    acc_wdata = '0;
    row_out   = '0;
    for (int i = 0; i < LANES; i++) begin
      acc_wdata[i*ACC_W +: ACC_W] = acc_update(acc_rd[i*ACC_W +: ACC_W],
                                               bus.in_data[i*DATA_W +: DATA_W],
                                               tok_cnt == '0);
      row_out[i*DATA_W +: DATA_W] = scale(acc_rd[i*ACC_W +: ACC_W], recip);
    end
  end

  // No reset on the storage: the first token of every run overwrites each row.
  always_ff @(posedge clk) begin
    if (accept) acc_mem[row_cnt] <= acc_wdata;
  end

  pool_recip_divider #(
    .MAX_TOKENS (MAX_TOKENS),
    .RECIP_FRAC (RECIP_FRAC)
  ) u_recip (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .divisor  (n_lat),
    .done     (div_done),
    .quotient (recip)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      n_lat         <= '0;
      tok_cnt       <= '0;
      row_cnt       <= '0;
      run_err       <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      bus.in_ready  <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_last  <= 1'b0;
      bus.out_data  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          error <= 1'b0;
          if (start) begin
            busy <= 1'b1;
            if (sequence_length == '0 || sequence_length > N_W'(MAX_TOKENS)) begin
              run_err <= 1'b1;
              state   <= DONE;
            end else begin
              run_err      <= 1'b0;
              n_lat        <= sequence_length;
              tok_cnt      <= '0;
              row_cnt      <= '0;
              bus.in_ready <= 1'b1;
              state        <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (accept) begin
            row_cnt <= row_last ? '0 : row_cnt + ROW_W'(1);
            if (row_last) begin
              tok_cnt <= tok_cnt + N_W'(1);
              if (div_start) begin
                bus.in_ready <= 1'b0;
                state        <= RECIP;
              end
            end
          end
        end
        RECIP: begin
          if (div_done) begin
            row_cnt <= '0;
            state   <= EMIT;
          end
        end
        EMIT: begin
          // Final row accepted ends the run; otherwise refill when the slot is free.
          if (bus.out_valid && bus.out_ready && bus.out_last) begin
            bus.out_valid <= 1'b0;
            bus.out_last  <= 1'b0;
            state         <= DONE;
          end else if (!bus.out_valid || bus.out_ready) begin
            bus.out_data  <= row_out;
            bus.out_last  <= row_last;
            bus.out_valid <= 1'b1;
            row_cnt       <= row_last ? '0 : row_cnt + ROW_W'(1);
          end
        end
        DONE: begin
          done  <= 1'b1;
          error <= run_err;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
